// File: rtl/wb_mem_slave_if.sv
// Wishbone B4 pipelined bus bundle shared by a single master and wb_mem_slave.
interface wb_mem_slave_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        stall;

  modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack, stall);
  modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack, stall);
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave over a word-addressed 32-bit memory, one access at a time,
// WAIT_CYCLES wait states, stall-based backpressure. Memory is split into byte lanes.
module wb_mem_lane #(
  parameter int ADDR_WIDTH = 10,
  parameter int LANE_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [LANE_W-1:0]     wdat,
  output logic [LANE_W-1:0]     rdat
);
  // Storage has no reset so its contents survive rst_i; only the read register clears.
  logic [LANE_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i)
    if (wr_en) mem[idx] <= wdat;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)      rdat <= '0;
    else if (rd_en) rdat <= mem[idx];
endmodule

module wb_mem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_mem_slave_if.slave wb
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic                  we;
    logic [NUM_LANES-1:0]  sel;
    logic [31:0]           dat;
  } req_t;

  logic [1:0] state;
  logic [3:0] cnt;
  req_t       req_q, req_in, req_cur;
  logic       accept, commit;
  logic [NUM_LANES-1:0][LANE_W-1:0] rdat_l;

  logic unused_adr;
  assign unused_adr = ^{wb.adr[31:ADDR_WIDTH+2], wb.adr[1:0]};

  assign req_in = '{idx: wb.adr[ADDR_WIDTH+1:2], we: wb.we, sel: wb.sel, dat: wb.dat_w};
  assign accept = (state == S_IDLE) && wb.cyc && wb.stb;

  // Memory is touched on the edge entering ACK; a dropped cyc in WAIT discards the access.
  assign commit  = (accept && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && wb.cyc && (cnt == 4'd0));
  assign req_cur = (state == S_IDLE) ? req_in : req_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      req_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          req_q <= req_in;
          cnt   <= CNT_INIT;
          state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
        end
        S_WAIT: begin
          if (!wb.cyc)             state <= S_IDLE;
          else if (cnt == 4'd0)    state <= S_ACK;
          else                     cnt   <= cnt - 4'd1;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      wb_mem_lane #(.ADDR_WIDTH(ADDR_WIDTH), .LANE_W(LANE_W)) u_lane (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_en (commit && req_cur.we && req_cur.sel[i]),
        .rd_en (commit && !req_cur.we),
        .idx   (req_cur.idx),
        .wdat  (req_cur.dat[LANE_W*i +: LANE_W]),
        .rdat  (rdat_l[i])
      );
    end
  endgenerate

  assign wb.dat_r = rdat_l;
  assign wb.ack   = (state == S_ACK);
  assign wb.stall = (state != S_IDLE);
endmodule
